// File: rtl/img_pkt_pkg.sv
// ---------------------------------------------------------------------------
// img_pkt_pkg
// Shared definitions for the framed pixel-packet receiver:
//   - protocol byte codes (SYNC, ACK, NAK)
//   - parser state encoding
//   - pixel width and the checksum fold helper
// ---------------------------------------------------------------------------
package img_pkt_pkg;

  localparam int PIX_W = 12;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  // Parser states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LEN   = 3'd1;
  localparam state_t ST_HI    = 3'd2;
  localparam state_t ST_LO    = 3'd3;
  localparam state_t ST_CHK   = 3'd4;
  localparam state_t ST_DRAIN = 3'd5;

  // Running checksum: plain 8-bit XOR, no carries.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/img_pkt_rx_buf.sv
// ---------------------------------------------------------------------------
// pkt_pix_buf
// Packet pixel buffer: DEPTH x W register file with write and read pointers.
// Ports:
//   i_clk      clock
//   i_rst_n    synchronous active-low reset (pointers to 0)
//   i_clr      drop contents (pointers to 0), wins over write/read
//   i_wr_en    write i_wr_data at the write pointer, advance it
//   i_wr_data  pixel to store
//   i_rd_en    advance the read pointer
//   o_rd_data  entry at the read pointer (combinational)
// ---------------------------------------------------------------------------
module pkt_pix_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 12
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Pointers need one extra bit so "full" (== DEPTH) is representable.
  localparam int PW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          w_wr_ok;

  assign w_wr_ok   = i_wr_en && (r_wr_ptr < PTR_FULL);
  assign o_rd_data = r_mem[r_rd_ptr[IW-1:0]];

  // Pointer update: clear has priority, reads never pass the write pointer
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_rd_en && (r_rd_ptr < r_wr_ptr)) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage array; contents are only read after being written in a packet
  always_ff @(posedge i_clk) begin
    if (w_wr_ok && !i_clr) begin
      r_mem[r_wr_ptr[IW-1:0]] <= i_wr_data;
    end
  end

endmodule

// File: rtl/img_pkt_rx.sv
// ---------------------------------------------------------------------------
// img_pkt_rx
// Framed pixel-packet receiver between uart_rx and the frame-RAM writer.
// Parses SYNC/LEN/payload/CHK packets, buffers the pixels, releases them as a
// one-per-cycle burst once the checksum matches, and answers ACK/NAK.
// Ports:
//   i_clk_sys, i_rst_n    clock, synchronous active-low reset
//   i_enable              image-receive window
//   i_rx_data, i_rx_done  received byte and its one-cycle strobe
//   o_pix, o_pix_valid    released pixel {R,G,B} and strobe
//   o_ack_data/_valid     reply byte (0x06 / 0x15) and strobe
//   o_pix_cnt             pixels released in the current image (saturating)
//   o_frame_done          strobe with the pixel that completes the image
//   o_err                 strobe on any protocol error
// ---------------------------------------------------------------------------
module img_pkt_rx
  import img_pkt_pkg::*;
#(
  parameter int PKT_PIX_MAX = 16,
  parameter int FRAME_PIX   = 37000,
  parameter int TIMEOUT_CYC = 262144
) (
  input  logic             i_clk_sys,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_done,
  output logic [PIX_W-1:0] o_pix,
  output logic             o_pix_valid,
  output logic [7:0]       o_ack_data,
  output logic             o_ack_valid,
  output logic [15:0]      o_pix_cnt,
  output logic             o_frame_done,
  output logic             o_err
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1'b1);
  localparam logic [7:0]    LEN_MAX    = 8'(PKT_PIX_MAX);
  localparam logic [15:0]   FRAME_LAST = 16'(FRAME_PIX - 1);
  localparam logic [15:0]   FRAME_FULL = 16'(FRAME_PIX);

  state_t           r_state;
  logic [7:0]       r_len;
  logic [7:0]       r_cnt;
  logic [7:0]       r_chk;
  logic [3:0]       r_hi;
  logic [TW-1:0]    r_tmo;
  logic             r_en_d;
  logic             r_full;
  logic [15:0]      r_pix_cnt;
  logic [PIX_W-1:0] r_pix;
  logic             r_pix_valid;
  logic [7:0]       r_ack_data;
  logic             r_ack_valid;
  logic             r_frame_done;
  logic             r_err;

  state_t           w_state_nxt;
  logic [7:0]       w_len_nxt;
  logic [7:0]       w_cnt_nxt;
  logic [7:0]       w_chk_nxt;
  logic [3:0]       w_hi_nxt;
  logic [7:0]       w_cnt_inc;
  logic             w_waiting;
  logic             w_tmo_hit;
  logic             w_en_rise;
  logic             w_len_ok;
  logic             w_buf_clr;
  logic             w_buf_wr;
  logic             w_buf_rd;
  logic             w_emit;
  logic             w_reply;
  logic [7:0]       w_reply_byte;
  logic             w_err;
  logic             w_frame_hit;
  logic [PIX_W-1:0] w_rd_data;

  assign w_cnt_inc   = r_cnt + 8'd1;
  assign w_waiting   = (r_state == ST_LEN) || (r_state == ST_HI) ||
                       (r_state == ST_LO)  || (r_state == ST_CHK);
  assign w_tmo_hit   = w_waiting && (r_tmo == TMO_LAST);
  assign w_en_rise   = i_enable && !r_en_d;
  assign w_len_ok    = (i_rx_data != 8'h00) && (i_rx_data <= LEN_MAX);
  assign w_frame_hit = w_emit && (r_pix_cnt == FRAME_LAST);

  pkt_pix_buf #(
    .DEPTH (PKT_PIX_MAX),
    .W     (PIX_W)
  ) u_buf (
    .i_clk     (i_clk_sys),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_buf_clr),
    .i_wr_en   (w_buf_wr),
    .i_wr_data ({r_hi, i_rx_data}),
    .i_rd_en   (w_buf_rd),
    .o_rd_data (w_rd_data)
  );

  // Parser next-state and per-cycle control decisions
  always_comb begin
    w_state_nxt  = r_state;
    w_len_nxt    = r_len;
    w_cnt_nxt    = r_cnt;
    w_chk_nxt    = r_chk;
    w_hi_nxt     = r_hi;
    w_buf_clr    = 1'b0;
    w_buf_wr     = 1'b0;
    w_buf_rd     = 1'b0;
    w_emit       = 1'b0;
    w_reply      = 1'b0;
    w_reply_byte = NAK_BYTE;
    w_err        = 1'b0;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
      w_buf_clr   = 1'b1;
    end else if (w_tmo_hit) begin
      // Stalled packet: abandon silently apart from the error strobe
      w_state_nxt = ST_IDLE;
      w_buf_clr   = 1'b1;
      w_err       = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_rx_done && (i_rx_data == SYNC_BYTE)) begin
            w_state_nxt = ST_LEN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_LEN: begin
          if (i_rx_done && w_len_ok) begin
            w_len_nxt   = i_rx_data;
            w_chk_nxt   = i_rx_data;
            w_cnt_nxt   = 8'd0;
            w_buf_clr   = 1'b1;
            w_state_nxt = ST_HI;
          end else if (i_rx_done) begin
            w_reply     = 1'b1;
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_LEN;
          end
        end
        ST_HI: begin
          if (i_rx_done) begin
            w_chk_nxt   = chk_fold(r_chk, i_rx_data);
            w_hi_nxt    = i_rx_data[3:0];
            w_state_nxt = ST_LO;
          end else begin
            w_state_nxt = ST_HI;
          end
        end
        ST_LO: begin
          if (i_rx_done) begin
            w_chk_nxt   = chk_fold(r_chk, i_rx_data);
            w_buf_wr    = 1'b1;
            w_cnt_nxt   = w_cnt_inc;
            w_state_nxt = (w_cnt_inc == r_len) ? ST_CHK : ST_HI;
          end else begin
            w_state_nxt = ST_LO;
          end
        end
        ST_CHK: begin
          if (i_rx_done && (i_rx_data == r_chk)) begin
            w_reply      = 1'b1;
            w_reply_byte = ACK_BYTE;
            if (r_full) begin
              // Image already complete: acknowledge but release nothing
              w_buf_clr   = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              // First pixel leaves together with the ACK
              w_emit      = 1'b1;
              w_buf_rd    = 1'b1;
              w_cnt_nxt   = 8'd1;
              w_buf_clr   = (r_len == 8'd1);
              w_state_nxt = (r_len == 8'd1) ? ST_IDLE : ST_DRAIN;
            end
          end else if (i_rx_done) begin
            w_reply     = 1'b1;
            w_err       = 1'b1;
            w_buf_clr   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_CHK;
          end
        end
        ST_DRAIN: begin
          w_err = i_rx_done;
          if (r_full) begin
            w_buf_clr   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_emit      = 1'b1;
            w_buf_rd    = 1'b1;
            w_cnt_nxt   = w_cnt_inc;
            w_buf_clr   = (w_cnt_inc == r_len);
            w_state_nxt = (w_cnt_inc == r_len) ? ST_IDLE : ST_DRAIN;
          end
        end
        default: begin
          w_buf_clr   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Parser state, timeout counter, image counters and registered outputs
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_len        <= 8'd0;
      r_cnt        <= 8'd0;
      r_chk        <= 8'd0;
      r_hi         <= 4'd0;
      r_tmo        <= '0;
      r_en_d       <= 1'b0;
      r_full       <= 1'b0;
      r_pix_cnt    <= 16'd0;
      r_pix        <= '0;
      r_pix_valid  <= 1'b0;
      r_ack_data   <= 8'd0;
      r_ack_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_chk   <= w_chk_nxt;
      r_hi    <= w_hi_nxt;
      r_en_d  <= i_enable;

      if (!i_enable || i_rx_done || !w_waiting || w_tmo_hit) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + TMO_ONE;
      end

      if (w_en_rise) begin
        r_pix_cnt <= 16'd0;
        r_full    <= 1'b0;
      end else begin
        if (w_emit && (r_pix_cnt != FRAME_FULL)) begin
          r_pix_cnt <= r_pix_cnt + 16'd1;
        end
        if (w_frame_hit) begin
          r_full <= 1'b1;
        end
      end

      r_pix        <= w_emit ? w_rd_data : '0;
      r_pix_valid  <= w_emit;
      r_ack_data   <= w_reply ? w_reply_byte : 8'd0;
      r_ack_valid  <= w_reply;
      r_frame_done <= w_frame_hit;
      r_err        <= w_err;
    end
  end

  assign o_pix        = r_pix;
  assign o_pix_valid  = r_pix_valid;
  assign o_ack_data   = r_ack_data;
  assign o_ack_valid  = r_ack_valid;
  assign o_pix_cnt    = r_pix_cnt;
  assign o_frame_done = r_frame_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_img_pkt_rx.sv
`timescale 1ns/1ps
module tb_img_pkt_rx;

  localparam int PKT_PIX_MAX = 16;
  localparam int FRAME_PIX   = 20;
  localparam int TIMEOUT_CYC = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic [11:0] o_pix;
  logic        o_pix_valid;
  logic [7:0]  o_ack_data;
  logic        o_ack_valid;
  logic [15:0] o_pix_cnt;
  logic        o_frame_done;
  logic        o_err;

  img_pkt_rx #(
    .PKT_PIX_MAX (PKT_PIX_MAX),
    .FRAME_PIX   (FRAME_PIX),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk_sys    (clk),
    .i_rst_n      (rst_n),
    .i_enable     (en),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .o_pix        (o_pix),
    .o_pix_valid  (o_pix_valid),
    .o_ack_data   (o_ack_data),
    .o_ack_valid  (o_ack_valid),
    .o_pix_cnt    (o_pix_cnt),
    .o_frame_done (o_frame_done),
    .o_err        (o_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Event logs captured on the falling edge
  logic [11:0] q_pix[$];
  int          q_pix_cyc[$];
  logic [7:0]  q_ack[$];
  int          q_ack_cyc[$];
  int          q_err_cyc[$];
  int          q_fd_cyc[$];

  always @(negedge clk) begin
    if (o_pix_valid) begin q_pix.push_back(o_pix); q_pix_cyc.push_back(cyc); end
    if (o_ack_valid) begin q_ack.push_back(o_ack_data); q_ack_cyc.push_back(cyc); end
    if (o_err) q_err_cyc.push_back(cyc);
    if (o_frame_done) q_fd_cyc.push_back(cyc);
  end

  // Reference model of the image: pixels released so far and frame-full flag
  int          m_cnt = 0;
  bit          m_full = 1'b0;
  logic [7:0]  tx_q[$];
  logic [11:0] src_pix[$];
  int          last_cyc = 0;

  typedef struct packed {
    logic [3:0]      nbytes;
    logic [0:7][7:0] bytes;
    logic            ack_vld;
    logic [7:0]      ack;
    logic [3:0]      err;
    logic [4:0]      npix;
    logic [11:0]     pix0;
    logic [15:0]     cnt;
  } vec_t;
  vec_t tbl [0:5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    q_pix.delete(); q_pix_cyc.delete(); q_ack.delete(); q_ack_cyc.delete();
    q_err_cyc.delete(); q_fd_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_done  = 1'b1;
    last_cyc = cyc;
    tick(1);
    rx_done  = 1'b0;
    tick(gap);
  endtask

  task automatic send_q(input int gap);
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], gap);
  endtask

  task automatic toggle_en();
    en = 1'b0; tick(3);
    en = 1'b1; tick(2);
    m_cnt = 0; m_full = 1'b0;
  endtask

  // Packet of random pixels; HI upper nibble is random noise that must be ignored
  task automatic build_pkt(input int len, input bit bad_chk);
    logic [7:0]  chk, hi, lo;
    logic [11:0] p;
    logic [3:0]  nib;
    tx_q.delete(); src_pix.delete();
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'(len));
    chk = 8'(len);
    for (int i = 0; i < len; i++) begin
      p   = 12'($urandom_range(0, 4095));
      nib = 4'($urandom_range(0, 15));
      hi  = {nib, p[11:8]};
      lo  = p[7:0];
      chk = chk ^ hi ^ lo;
      tx_q.push_back(hi); tx_q.push_back(lo);
      src_pix.push_back(p);
    end
    if (bad_chk) chk = chk ^ 8'($urandom_range(1, 255));
    tx_q.push_back(chk);
  endtask

  // Good packet: how many pixels the image still accepts, and whether it completes
  task automatic model_good(input int len, output int npix, output int fd);
    if (m_full) begin
      npix = 0; fd = 0;
    end else begin
      npix  = (len < FRAME_PIX - m_cnt) ? len : FRAME_PIX - m_cnt;
      m_cnt = m_cnt + npix;
      fd    = (m_cnt == FRAME_PIX) ? 1 : 0;
      m_full = (fd == 1);
    end
  endtask

  // kind: 0 good, 1 bad checksum, 2 bad length, 3 stray byte
  task automatic run_txn(input string name, input int kind, input int len);
    int npix = 0;
    int fd = 0;
    logic [7:0] s;
    clear_logs();
    case (kind)
      0: begin build_pkt(len, 1'b0); model_good(len, npix, fd); end
      1: build_pkt(len, 1'b1);
      2: begin tx_q.delete(); tx_q.push_back(8'hA5); tx_q.push_back(8'(len)); end
      default: begin
        do s = 8'($urandom_range(0, 255)); while (s == 8'hA5);
        tx_q.delete(); tx_q.push_back(s);
      end
    endcase
    send_q(3);
    tick(PKT_PIX_MAX + 6);
    check({name, "_nack"}, q_ack.size(), (kind == 3) ? 0 : 1);
    if (kind != 3 && q_ack.size() > 0)
      check({name, "_ackbyte"}, q_ack[0], (kind == 0) ? 8'h06 : 8'h15);
    check({name, "_nerr"}, q_err_cyc.size(), (kind == 1 || kind == 2) ? 1 : 0);
    check({name, "_npix"}, q_pix.size(), npix);
    for (int i = 0; i < npix; i++)
      if (i < q_pix.size()) check($sformatf("%s_pix%0d", name, i), q_pix[i], src_pix[i]);
    check({name, "_nfd"}, q_fd_cyc.size(), fd);
    check({name, "_cnt"}, o_pix_cnt, m_cnt);
  endtask

  initial begin
    int r, len, npix_before;

    // Directed vectors, applied with the image counter freshly cleared.
    // XOR of 02 0F 12 03 45 is 0x59.
    tbl[0] = '{4'd7, {8'hA5, 8'h02, 8'h0F, 8'h12, 8'h03, 8'h45, 8'h59, 8'h00},
               1'b1, 8'h06, 4'd0, 5'd2, 12'hF12, 16'd2};
    tbl[1] = '{4'd7, {8'hA5, 8'h02, 8'h0F, 8'h12, 8'h03, 8'h45, 8'h00, 8'h00},
               1'b1, 8'h15, 4'd1, 5'd0, 12'h000, 16'd2};
    tbl[2] = '{4'd2, {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               1'b1, 8'h15, 4'd1, 5'd0, 12'h000, 16'd2};
    tbl[3] = '{4'd2, {8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               1'b1, 8'h15, 4'd1, 5'd0, 12'h000, 16'd2};
    tbl[4] = '{4'd1, {8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               1'b0, 8'h00, 4'd0, 5'd0, 12'h000, 16'd2};
    tbl[5] = '{4'd5, {8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h67, 8'h00, 8'h00, 8'h00},
               1'b1, 8'h06, 4'd0, 5'd1, 12'hBCD, 16'd3};

    // Reset state
    tick(3);
    check("rst_pix", o_pix, 0);
    check("rst_pix_valid", o_pix_valid, 0);
    check("rst_ack_data", o_ack_data, 0);
    check("rst_ack_valid", o_ack_valid, 0);
    check("rst_pix_cnt", o_pix_cnt, 0);
    check("rst_strobes", {o_frame_done, o_err}, 0);
    rst_n = 1'b1; tick(1);
    en = 1'b1; tick(2);

    // Latency of ACK and the pixel burst relative to the CHK strobe
    clear_logs();
    for (int b = 0; b < 7; b++) begin
      tx_q.delete();
    end
    for (int b = 0; b < 7; b++) tx_q.push_back(tbl[0].bytes[b]);
    send_q(3);
    tick(10);
    check("lat_nack", q_ack.size(), 1);
    check("lat_npix", q_pix.size(), 2);
    if (q_ack.size() == 1 && q_pix.size() == 2) begin
      check("lat_ack_cyc", q_ack_cyc[0], last_cyc + 1);
      check("lat_pix0_cyc", q_pix_cyc[0], last_cyc + 1);
      check("lat_pix1_cyc", q_pix_cyc[1], last_cyc + 2);
      check("lat_pix1", q_pix[1], 12'h345);
    end
    check("lat_cnt", o_pix_cnt, 2);

    // Table-driven directed vectors
    toggle_en();
    check("toggle_cnt0", o_pix_cnt, 0);
    for (int v = 0; v < 6; v++) begin
      clear_logs();
      tx_q.delete();
      for (int b = 0; b < int'(tbl[v].nbytes); b++) tx_q.push_back(tbl[v].bytes[b]);
      send_q(3);
      tick(PKT_PIX_MAX + 6);
      check($sformatf("vec%0d_nack", v), q_ack.size(), tbl[v].ack_vld ? 1 : 0);
      if (tbl[v].ack_vld && q_ack.size() > 0) check($sformatf("vec%0d_ack", v), q_ack[0], tbl[v].ack);
      check($sformatf("vec%0d_nerr", v), q_err_cyc.size(), tbl[v].err);
      check($sformatf("vec%0d_npix", v), q_pix.size(), tbl[v].npix);
      if (tbl[v].npix > 0 && q_pix.size() > 0) check($sformatf("vec%0d_pix0", v), q_pix[0], tbl[v].pix0);
      check($sformatf("vec%0d_cnt", v), o_pix_cnt, tbl[v].cnt);
    end
    toggle_en();

    // Timeout inside a packet, then a normal packet
    clear_logs();
    tx_q.delete(); tx_q.push_back(8'hA5); tx_q.push_back(8'h02); tx_q.push_back(8'h0F);
    send_q(0);
    tick(TIMEOUT_CYC + 8);
    check("tmo_nerr", q_err_cyc.size(), 1);
    check("tmo_nack", q_ack.size(), 0);
    if (q_err_cyc.size() > 0)
      check("tmo_when", (q_err_cyc[0] >= last_cyc + TIMEOUT_CYC) &&
                        (q_err_cyc[0] <= last_cyc + TIMEOUT_CYC + 2), 1);
    run_txn("tmo_next", 0, 2);

    // End of frame with FRAME_PIX = 20
    toggle_en();
    run_txn("frm_a", 0, 16);
    run_txn("frm_b", 0, 16);
    if (q_pix.size() >= 4 && q_fd_cyc.size() >= 1) begin
      check("frm_fd_cyc", q_fd_cyc[0], q_pix_cyc[3]);
      check("frm_contig", q_pix_cyc[3] - q_pix_cyc[0], 3);
    end else begin
      check("frm_fd_seen", 0, 1);
    end
    run_txn("frm_c", 0, 5);
    toggle_en();
    check("frm_cnt_clr", o_pix_cnt, 0);

    // Byte arriving mid-burst: error strobe, burst continues
    begin
      int np, fd;
      clear_logs();
      build_pkt(16, 1'b0);
      model_good(16, np, fd);
      send_q(0);
      tick(2);
      send_byte(8'h33, 0);
      tick(PKT_PIX_MAX + 6);
      check("drn_nerr", q_err_cyc.size(), 1);
      check("drn_npix", q_pix.size(), np);
      check("drn_nack", q_ack.size(), 1);
      check("drn_cnt", o_pix_cnt, m_cnt);
    end

    // Enable dropped mid-payload
    clear_logs();
    tx_q.delete(); tx_q.push_back(8'hA5); tx_q.push_back(8'h02); tx_q.push_back(8'h0F);
    send_q(3);
    en = 1'b0; tick(1);
    check("endrop_strobes", {o_pix_valid, o_ack_valid, o_err, o_frame_done}, 0);
    check("endrop_data", {o_pix, o_ack_data}, 0);
    check("endrop_cnt_kept", o_pix_cnt, m_cnt);
    en = 1'b1; tick(2);
    m_cnt = 0; m_full = 1'b0;
    run_txn("endrop_next", 0, 3);

    // Reset in the middle of a burst
    clear_logs();
    build_pkt(16, 1'b0);
    send_q(3);
    rst_n = 1'b0; tick(1);
    check("rstdrn_strobes", {o_pix_valid, o_ack_valid, o_err, o_frame_done}, 0);
    check("rstdrn_data", {o_pix, o_ack_data}, 0);
    check("rstdrn_cnt", o_pix_cnt, 0);
    npix_before = q_pix.size();
    rst_n = 1'b1;
    tick(PKT_PIX_MAX + 4);
    check("rstdrn_aborted", q_pix.size(), npix_before);
    m_cnt = 0; m_full = 1'b0;
    run_txn("rstdrn_next", 0, 4);

    // Randomised traffic against the model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 7) == 0) toggle_en();
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        run_txn($sformatf("rnd%0d", t), 0, $urandom_range(1, PKT_PIX_MAX));
      end else if (r <= 7) begin
        run_txn($sformatf("rnd%0d", t), 1, $urandom_range(1, PKT_PIX_MAX));
      end else if (r == 8) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(PKT_PIX_MAX + 1, 255);
        run_txn($sformatf("rnd%0d", t), 2, len);
      end else begin
        run_txn($sformatf("rnd%0d", t), 3, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
